// File: rtl/fixp_pkg.sv
// Shared fixed-point definitions for the multiplier/divider pair: default format,
// divider iteration count, FSM state encoding and saturation limits.
package fixp_pkg;

    localparam int DEF_SCALE = 25;
    localparam int DEF_WIDTH = 32;

    // One restoring step per bit of the widened dividend |a| << scale.
    function automatic int iter_count(input int width, input int scale);
        return width + 1 + scale;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [DEF_WIDTH:0] MAX_POS = {1'b0, {DEF_WIDTH{1'b1}}};
    localparam logic [DEF_WIDTH:0] MIN_NEG = {1'b1, {DEF_WIDTH{1'b0}}};

endpackage

// File: rtl/fixp_div_if.sv
// Start/done handshake bundle between a controller (master) and the divider (slave).
interface fixp_div_if #(
    parameter int WIDTH = fixp_pkg::DEF_WIDTH
);
    logic                    start;
    logic signed [WIDTH:0]   a;
    logic signed [WIDTH:0]   b;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH:0]   res;
    logic                    ovf;
    logic                    dbz;

    modport master (
        output start, a, b,
        input  busy, done, res, ovf, dbz
    );

    modport slave (
        input  start, a, b,
        output busy, done, res, ovf, dbz
    );
endinterface

// File: rtl/fixp_div_step.sv
// One unsigned restoring-division step: shift in the next dividend bit and
// subtract the divisor when it fits.
module fixp_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH:0]   i_div,
    output logic [WIDTH+1:0] o_rem,
    output logic             o_q
);
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_div_ext;

    assign w_shift   = {i_rem[WIDTH:0], i_bit};
    assign w_div_ext = {1'b0, i_div};

    // A set remainder MSB means the shifted value left the window, so it surely fits.
    assign o_q   = i_rem[WIDTH+1] | (w_shift >= w_div_ext);
    assign o_rem = o_q ? (w_shift - w_div_ext) : w_shift;
endmodule

// File: rtl/fixp_div.sv
// Iterative signed fixed-point divider: res = (a << SCALE) / b, truncated toward
// zero, with saturation on overflow and divide-by-zero.
module fixp_div
    import fixp_pkg::*;
#(
    parameter int SCALE = DEF_SCALE,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    fixp_div_if.slave bus
);
    localparam int ITER  = iter_count(WIDTH, SCALE);
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [WIDTH:0] SAT_POS = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] SAT_NEG = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [ITER-1:0]  r_dvd;
    logic [ITER-1:0]  r_q;
    logic [WIDTH+1:0] r_rem;
    logic [WIDTH:0]   r_div;
    logic             r_sign;
    logic             r_a_neg;
    logic             r_b_zero;

    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic             r_dbz;
    logic [WIDTH:0]   r_res;

    logic             w_accept;
    logic [WIDTH:0]   w_a_mag;
    logic [WIDTH:0]   w_b_mag;
    logic [WIDTH+1:0] w_rem;
    logic             w_qbit;
    logic [WIDTH:0]   w_q_lo;
    logic             w_ovf_pos;
    logic             w_ovf_neg;
    logic [WIDTH:0]   w_res_next;
    logic             w_ovf_next;

    // busy is still high in the done cycle, which keeps a start there from being taken.
    assign w_accept = (r_state == IDLE) && bus.start && !r_busy;

    // Magnitudes are unsigned width+1 bits so -2^WIDTH maps to 2^WIDTH exactly.
    assign w_a_mag = bus.a[WIDTH] ? (~bus.a + ONE) : bus.a;
    assign w_b_mag = bus.b[WIDTH] ? (~bus.b + ONE) : bus.b;

    fixp_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[ITER-1]),
        .i_div (r_div),
        .o_rem (w_rem),
        .o_q   (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = CALC;
            CALC:    if (r_cnt == CNT_W'(1)) w_state_next = FIN;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The negative range reaches one step further than the positive one.
    assign w_q_lo    = r_q[WIDTH:0];
    assign w_ovf_pos = |r_q[ITER-1:WIDTH];
    assign w_ovf_neg = (|r_q[ITER-1:WIDTH+1]) | (r_q[WIDTH] & (|r_q[WIDTH-1:0]));

    always_comb begin
        w_res_next = r_sign ? (~w_q_lo + ONE) : w_q_lo;
        w_ovf_next = 1'b0;
        if (r_b_zero) begin
            w_res_next = r_a_neg ? SAT_NEG : SAT_POS;
        end else if (!r_sign && w_ovf_pos) begin
            w_res_next = SAT_POS;
            w_ovf_next = 1'b1;
        end else if (r_sign && w_ovf_neg) begin
            w_res_next = SAT_NEG;
            w_ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_sign   <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
            r_res    <= '0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (r_state != IDLE);
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign   <= bus.a[WIDTH] ^ bus.b[WIDTH];
                        r_a_neg  <= bus.a[WIDTH];
                        r_b_zero <= (bus.b == '0);
                        r_div    <= w_b_mag;
                        r_dvd    <= {w_a_mag, {SCALE{1'b0}}};
                        r_rem    <= '0;
                        r_q      <= '0;
                        r_cnt    <= CNT_W'(ITER);
                        r_ovf    <= 1'b0;
                        r_dbz    <= 1'b0;
                    end
                end
                CALC: begin
                    r_dvd <= r_dvd << 1;
                    r_q   <= {r_q[ITER-2:0], w_qbit};
                    r_rem <= w_rem;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                FIN: begin
                    r_res  <= w_res_next;
                    r_ovf  <= w_ovf_next;
                    r_dbz  <= r_b_zero;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.res  = r_res;
    assign bus.ovf  = r_ovf;
    assign bus.dbz  = r_dbz;
endmodule
